ppu_vram_port: RTL and testbench
================================

// Module: ppu_vram_port
// PURPOSE
//   CPU-facing PPU register port driving the PPU VRAM/palette RAM. Decodes CPU accesses to
//   PPUCTRL ($2000), PPUSTATUS ($2002), PPUSCROLL ($2005), PPUADDR ($2006) and PPUDATA ($2007).
//   Maintains the 14-bit VRAM address v, the shared write toggle w and the PPUDATA read buffer.
//   Feeds the RAM's we/w_addr/w_data and r_addr; consumes its combinational r_data.
// PARAMETERS
//   INC_SMALL   1    v increment when PPUCTRL[2]=0
//   INC_LARGE   32   v increment when PPUCTRL[2]=1
// PORTS
//   clock         in   1   single clock; all state changes on posedge
//   reset         in   1   synchronous, active-low; sampled on posedge clock
//   cpu_cs        in   1   one-cycle access strobe; sampled only when cpu_busy=0
//   cpu_rw        in   1   1=read, 0=write
//   cpu_addr      in   3   register index ($2000+cpu_addr)
//   cpu_wdata     in   8   write data
//   cpu_rdata     out  8   registered read data, valid cycle after cs
//   cpu_busy      out  1   port mid-sequence; CPU must hold off cs
//   vram_we       out  1   RAM write enable, one cycle per PPUDATA write
//   vram_w_addr   out  16  RAM write address, {2'b00, v_old}
//   vram_w_data   out  8   RAM write data
//   vram_r_addr   out  14  RAM read address (combinational from state)
//   vram_r_data   in   8   RAM read data, combinational from vram_r_addr
// BEHAVIOUR
//   Reset (reset=0): v=0, t_hi=0, w=0, inc32=0, rbuf=0, cpu_rdata=0, cpu_busy=0, vram_we=0,
//     vram_w_addr=0, vram_w_data=0, state=IDLE. Reset in any state aborts to IDLE.
//   inc = inc32 ? INC_LARGE : INC_SMALL; v arithmetic is 14-bit, wraps $3FFF -> $0000.
//   vram_r_addr = v in IDLE, pal_base in PAL_FILL.
//   Access accepted at posedge when cpu_cs=1 and state=IDLE; everything below updates at that edge:
//   - Write $2000: inc32 <= cpu_wdata[2]. Other bits ignored.
//   - Write $2005: w <= ~w (scroll values not held here).
//   - Write $2006, w=0: t_hi <= cpu_wdata[5:0], w<=1. w=1: v <= {t_hi, cpu_wdata}, w<=0.
//   - Write $2007: vram_we<=1, vram_w_addr<={2'b00,v}, vram_w_data<=cpu_wdata, v<=v+inc.
//     vram_we high exactly one cycle; back-to-back writes give consecutive we pulses.
//   - Read $2002: w<=0; cpu_rdata<=8'h00 (status bits owned elsewhere).
//   - Read $2007 (buffered): cpu_rdata<=rbuf; rbuf<=vram_r_data (from v); v<=v+inc. Latency 1.
//   - Any other register/direction: cpu_rdata<=8'h00 on reads, writes ignored; no state change.
//   vram_we returns to 0 on any cycle without an accepted $2007 write.
//   States: IDLE, PAL_FILL (PAL_FILL only exists with the macro). cpu_busy=1 iff state=PAL_FILL.
//   cpu_cs while busy is ignored (no effect), a bench protocol error.
// CONFIGURATION
//   PPU_PALETTE_DIRECT_READ_EN defined: $2007 read with v[13:8]==6'h3F:
//     accept edge: cpu_rdata<=vram_r_data (palette byte, unbuffered), pal_base<=v & 14'h2FFF,
//     v<=v+inc, state->PAL_FILL; PAL_FILL edge: rbuf<=vram_r_data (nametable under palette),
//     state->IDLE. cpu_busy high exactly one cycle.
//   Undefined: palette reads take the buffered path like all others; PAL_FILL absent, cpu_busy tied 0.
// STRUCTURE
//   Package ppu_pkg: register index localparams (REG_CTRL=0, REG_STATUS=2, REG_SCROLL=5,
//     REG_ADDR=6, REG_DATA=7), state enum, PAL_PAGE=6'h3F, PAL_MIRROR_MASK=14'h2FFF.
//   One sub-module natural: ppu_vaddr_reg (v, t_hi, w, inc select/increment); rest flat.
// TESTING
//   1. Reset low 2 cycles -> all outputs 0, v=0; release -> vram_r_addr=0, busy=0.
//   2. Write $2006=$21,$2006=$08, $2007=$AB -> vram_we one cycle, w_addr=$2108, w_data=$AB, v=$2109.
//   3. $2000=$04, then two $2007 writes from v=$2000 -> w_addr $2000 then $2020; v=$2040.
//   4. RAM[$2400]=$5A,[$2401]=$C3; v=$2400; read $2007 x3 -> rdata old rbuf, $5A, $C3.
//   5. Write $2006 once, read $2002, write $2006=$3F,$2006=$00 -> v=$3F00 (toggle cleared).
//   6. Macro on, RAM[$3F00]=$0F,[$2F00]=$77, v=$3F00: read -> rdata=$0F, busy 1 cycle, rbuf=$77;
//      macro off -> rdata=old rbuf, rbuf=$0F, busy never high; v=$3FFF + inc 1 wraps to $0000.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared register indices, FSM state type and palette constants for the PPU register port.
package ppu_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_SCROLL = 3'd5;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam logic [5:0]  PAL_PAGE        = 6'h3F;
  localparam logic [13:0] PAL_MIRROR_MASK = 14'h2FFF;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_PAL_FILL = 1'b1
  } state_e;

endpackage

// File: rtl/ppu_vaddr_reg.sv
// VRAM address state: 14-bit v, high-byte latch t_hi, shared write toggle w and the
// PPUCTRL increment select. All updates are single-cycle on the accept edge.
module ppu_vaddr_reg #(
  parameter int INC_SMALL = 1,
  parameter int INC_LARGE = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_wr_i,
  input  logic        scroll_wr_i,
  input  logic        addr_wr_i,
  input  logic        status_rd_i,
  input  logic        inc_i,
  input  logic [7:0]  wdata_i,
  output logic [13:0] v_o
);

  localparam logic [13:0] STEP_SMALL = 14'(INC_SMALL);
  localparam logic [13:0] STEP_LARGE = 14'(INC_LARGE);

  logic [13:0] v_q, v_d;
  logic [5:0]  t_hi_q, t_hi_d;
  logic        w_q, w_d;
  logic        inc32_q, inc32_d;
  logic [13:0] step;

  assign step = inc32_q ? STEP_LARGE : STEP_SMALL;
  assign v_o  = v_q;

  always_comb begin
    v_d     = v_q;
    t_hi_d  = t_hi_q;
    w_d     = w_q;
    inc32_d = inc32_q;
    if (ctrl_wr_i)   inc32_d = wdata_i[2];
    if (scroll_wr_i) w_d = ~w_q;
    if (addr_wr_i) begin
      if (!w_q) begin
        t_hi_d = wdata_i[5:0];
        w_d    = 1'b1;
      end else begin
        v_d = {t_hi_q, wdata_i};
        w_d = 1'b0;
      end
    end
    if (status_rd_i) w_d = 1'b0;
    // 14-bit add wraps $3FFF -> $0000 naturally
    if (inc_i) v_d = v_q + step;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      v_q     <= '0;
      t_hi_q  <= '0;
      w_q     <= 1'b0;
      inc32_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      t_hi_q  <= t_hi_d;
      w_q     <= w_d;
      inc32_q <= inc32_d;
    end
  end

endmodule

// File: rtl/ppu_vram_port.sv
// CPU-facing PPU register port driving VRAM/palette RAM; PPUDATA reads are buffered.
// PPU_PALETTE_DIRECT_READ_EN: palette-page reads return unbuffered and refill rbuf in a 1-cycle busy state.
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int INC_SMALL = 1,
  parameter int INC_LARGE = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_busy,
  output logic        vram_we,
  output logic [15:0] vram_w_addr,
  output logic [7:0]  vram_w_data,
  output logic [13:0] vram_r_addr,
  input  logic [7:0]  vram_r_data
);

  state_e      state_q, state_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        we_q, we_d;
  logic [15:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [13:0] pal_base_q, pal_base_d;
  logic [13:0] v;
  logic        accept, wr_acc, rd_acc, data_wr, data_rd, pal_hit;

  assign accept  = cpu_cs && (state_q == ST_IDLE);
  assign wr_acc  = accept && !cpu_rw;
  assign rd_acc  = accept && cpu_rw;
  assign data_wr = wr_acc && (cpu_addr == REG_DATA);
  assign data_rd = rd_acc && (cpu_addr == REG_DATA);

`ifdef PPU_PALETTE_DIRECT_READ_EN
  assign pal_hit = (v[13:8] == PAL_PAGE);
`else
  assign pal_hit = 1'b0;
`endif

  ppu_vaddr_reg #(
    .INC_SMALL(INC_SMALL),
    .INC_LARGE(INC_LARGE)
  ) u_vaddr (
    .clock       (clock),
    .reset       (reset),
    .ctrl_wr_i   (wr_acc && (cpu_addr == REG_CTRL)),
    .scroll_wr_i (wr_acc && (cpu_addr == REG_SCROLL)),
    .addr_wr_i   (wr_acc && (cpu_addr == REG_ADDR)),
    .status_rd_i (rd_acc && (cpu_addr == REG_STATUS)),
    .inc_i       (data_wr || data_rd),
    .wdata_i     (cpu_wdata),
    .v_o         (v)
  );

  assign cpu_rdata   = rdata_q;
  assign cpu_busy    = (state_q == ST_PAL_FILL);
  assign vram_we     = we_q;
  assign vram_w_addr = waddr_q;
  assign vram_w_data = wdata_q;
  assign vram_r_addr = (state_q == ST_PAL_FILL) ? pal_base_q : v;

  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    rbuf_d     = rbuf_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    pal_base_d = pal_base_q;
    case (state_q)
      ST_IDLE: begin
        if (data_wr) begin
          we_d    = 1'b1;
          waddr_d = {2'b00, v};
          wdata_d = cpu_wdata;
        end
        if (rd_acc) rdata_d = 8'h00;
        if (data_rd) begin
          if (pal_hit) begin
            rdata_d    = vram_r_data;
            pal_base_d = v & PAL_MIRROR_MASK;
            state_d    = ST_PAL_FILL;
          end else begin
            rdata_d = rbuf_q;
            rbuf_d  = vram_r_data;
          end
        end
      end
      // r_addr points at the nametable byte hidden under the palette this cycle
      ST_PAL_FILL: begin
        rbuf_d  = vram_r_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rdata_q    <= '0;
      rbuf_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pal_base_q <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      rbuf_q     <= rbuf_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pal_base_q <= pal_base_d;
    end
  end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Bench for ppu_vram_port: directed scenarios plus randomized traffic against a behavioural model.
module tb_ppu_vram_port;

`ifdef PPU_PALETTE_DIRECT_READ_EN
  localparam bit PAL_MODE = 1'b1;
`else
  localparam bit PAL_MODE = 1'b0;
`endif

  logic        clock, reset, cpu_cs, cpu_rw;
  logic [2:0]  cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata, vram_w_data, vram_r_data;
  logic        cpu_busy, vram_we;
  logic [15:0] vram_w_addr;
  logic [13:0] vram_r_addr;

  logic [7:0] ram  [16384];
  logic [7:0] mram [16384];

  ppu_vram_port dut (
    .clock(clock), .reset(reset), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_busy(cpu_busy), .vram_we(vram_we), .vram_w_addr(vram_w_addr),
    .vram_w_data(vram_w_data), .vram_r_addr(vram_r_addr), .vram_r_data(vram_r_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign vram_r_data = ram[vram_r_addr];
  always @(posedge clock) if (vram_we) ram[vram_w_addr[13:0]] <= vram_w_data;

  int passed = 0;
  int total  = 0;

  // reference model state
  int mv, mt, mw, m32, mrbuf, mrdata;
  int exp_we, exp_waddr, exp_wdata, exp_busy;

  // observed results of the last access
  logic        got_we;
  logic [15:0] got_waddr;
  logic [7:0]  got_wdata, got_rdata;
  logic [13:0] got_v;
  int          got_busy;

  task automatic model_reset();
    mv = 0; mt = 0; mw = 0; m32 = 0; mrbuf = 0; mrdata = 0;
    exp_we = 0; exp_waddr = 0; exp_wdata = 0; exp_busy = 0;
  endtask

  task automatic model_op(input bit rw, input int a, input int d);
    int step;
    step = (m32 != 0) ? 32 : 1;
    exp_we = 0; exp_busy = 0;
    if (!rw) begin
      case (a)
        0: m32 = (d / 4) % 2;
        5: mw = 1 - mw;
        6: if (mw == 0) begin mt = d % 64; mw = 1; end
           else begin mv = mt * 256 + d; mw = 0; end
        7: begin
             exp_we = 1; exp_waddr = mv; exp_wdata = d;
             mram[mv] = 8'(d);
             mv = (mv + step) % 16384;
           end
        default: ;
      endcase
    end else begin
      case (a)
        2: begin mw = 0; mrdata = 0; end
        7: begin
             if (PAL_MODE && (mv / 256 == 63)) begin
               mrdata = mram[mv]; mrbuf = mram[mv & 'h2FFF]; exp_busy = 1;
             end else begin
               mrdata = mrbuf; mrbuf = mram[mv];
             end
             mv = (mv + step) % 16384;
           end
        default: mrdata = 0;
      endcase
    end
  endtask

  task automatic cpu_op(input bit rw, input logic [2:0] a, input logic [7:0] d);
    @(negedge clock);
    cpu_cs = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
    @(posedge clock); #1;
    cpu_cs = 1'b0;
    got_we = vram_we; got_waddr = vram_w_addr; got_wdata = vram_w_data; got_rdata = cpu_rdata;
    got_busy = 0;
    while (cpu_busy && got_busy < 4) begin
      got_busy++;
      @(posedge clock); #1;
    end
    got_v = vram_r_addr;
  endtask

  task automatic do_op(input bit rw, input int a, input int d);
    model_op(rw, a, d);
    cpu_op(rw, 3'(a), 8'(d));
  endtask

  task automatic poke(input int a, input int d);
    ram[a] = 8'(d); mram[a] = 8'(d);
  endtask

  task automatic test_reset();
    for (int it = 0; it < 2; it++) begin
      if (it == 1) begin
        cpu_op(0, 3'd6, 8'h15); cpu_op(0, 3'd6, 8'h55); cpu_op(0, 3'd7, 8'hE1); cpu_op(1, 3'd7, 8'h00);
      end
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      total++; if (cpu_rdata !== 8'h00) $display("FAIL reset%0d rdata got %h exp 00", it, cpu_rdata); else passed++;
      total++; if (vram_we !== 1'b0) $display("FAIL reset%0d we got %b exp 0", it, vram_we); else passed++;
      total++; if (vram_w_addr !== 16'h0 || vram_w_data !== 8'h0)
        $display("FAIL reset%0d waddr/wdata got %h/%h exp 0000/00", it, vram_w_addr, vram_w_data); else passed++;
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      total++; if (vram_r_addr !== 14'h0 || cpu_busy !== 1'b0)
        $display("FAIL reset%0d release r_addr/busy got %h/%b exp 0000/0", it, vram_r_addr, cpu_busy); else passed++;
      model_reset();
    end
  endtask

  task automatic test_addr_write();
    do_op(0, 6, 'h21); do_op(0, 6, 'h08); do_op(0, 7, 'hAB);
    total++; if (got_we !== 1'b1) $display("FAIL addrwr we got %b exp 1", got_we); else passed++;
    total++; if (got_waddr !== 16'h2108) $display("FAIL addrwr waddr got %h exp 2108", got_waddr); else passed++;
    total++; if (got_wdata !== 8'hAB) $display("FAIL addrwr wdata got %h exp AB", got_wdata); else passed++;
    total++; if (got_v !== 14'h2109) $display("FAIL addrwr v got %h exp 2109", got_v); else passed++;
    @(posedge clock); #1;
    total++; if (vram_we !== 1'b0) $display("FAIL addrwr we_drop got %b exp 0", vram_we); else passed++;
  endtask

  task automatic test_back_to_back();
    do_op(0, 0, 'h04); do_op(0, 6, 'h20); do_op(0, 6, 'h00);
    do_op(0, 7, 'h11);
    total++; if (got_we !== 1'b1 || got_waddr !== 16'h2000)
      $display("FAIL b2b first we/waddr got %b/%h exp 1/2000", got_we, got_waddr); else passed++;
    do_op(0, 7, 'h22);
    total++; if (got_we !== 1'b1 || got_waddr !== 16'h2020)
      $display("FAIL b2b second we/waddr got %b/%h exp 1/2020", got_we, got_waddr); else passed++;
    total++; if (got_v !== 14'h2040) $display("FAIL b2b v got %h exp 2040", got_v); else passed++;
    do_op(0, 0, 'h00);
  endtask

  task automatic test_buffered_read();
    int old;
    poke('h2400, 'h5A); poke('h2401, 'hC3);
    do_op(0, 6, 'h24); do_op(0, 6, 'h00);
    old = mrbuf;
    do_op(1, 7, 0);
    total++; if (got_rdata !== 8'(old)) $display("FAIL bufrd first got %h exp %h", got_rdata, 8'(old)); else passed++;
    do_op(1, 7, 0);
    total++; if (got_rdata !== 8'h5A) $display("FAIL bufrd second got %h exp 5A", got_rdata); else passed++;
    do_op(1, 7, 0);
    total++; if (got_rdata !== 8'hC3) $display("FAIL bufrd third got %h exp C3", got_rdata); else passed++;
    total++; if (got_v !== 14'h2403) $display("FAIL bufrd v got %h exp 2403", got_v); else passed++;
  endtask

  task automatic test_toggle();
    do_op(0, 6, 'h12);
    do_op(1, 2, 0);
    total++; if (got_rdata !== 8'h00) $display("FAIL toggle status got %h exp 00", got_rdata); else passed++;
    do_op(0, 6, 'h3F); do_op(0, 6, 'h00);
    total++; if (got_v !== 14'h3F00) $display("FAIL toggle v got %h exp 3F00", got_v); else passed++;
  endtask

  task automatic test_palette();
    int old;
    poke('h3F00, 'h0F); poke('h2F00, 'h77);
    do_op(0, 6, 'h3F); do_op(0, 6, 'h00);
    old = mrbuf;
    do_op(1, 7, 0);
    if (PAL_MODE) begin
      total++; if (got_rdata !== 8'h0F) $display("FAIL pal rdata got %h exp 0F", got_rdata); else passed++;
      total++; if (got_busy !== 1) $display("FAIL pal busy cycles got %0d exp 1", got_busy); else passed++;
      do_op(0, 6, 'h20); do_op(0, 6, 'h00); do_op(1, 7, 0);
      total++; if (got_rdata !== 8'h77) $display("FAIL pal rbuf got %h exp 77", got_rdata); else passed++;
    end else begin
      total++; if (got_rdata !== 8'(old)) $display("FAIL pal rdata got %h exp %h", got_rdata, 8'(old)); else passed++;
      total++; if (got_busy !== 0) $display("FAIL pal busy cycles got %0d exp 0", got_busy); else passed++;
      do_op(1, 7, 0);
      total++; if (got_rdata !== 8'h0F) $display("FAIL pal rbuf got %h exp 0F", got_rdata); else passed++;
    end
    do_op(0, 0, 'h00); do_op(0, 6, 'h3F); do_op(0, 6, 'hFF); do_op(0, 7, 'h05);
    total++; if (got_waddr !== 16'h3FFF) $display("FAIL wrap waddr got %h exp 3FFF", got_waddr); else passed++;
    total++; if (got_v !== 14'h0000) $display("FAIL wrap v got %h exp 0000", got_v); else passed++;
  endtask

  task automatic test_random();
    bit rw; int a, d;
    for (int n = 0; n < 400; n++) begin
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 7 : int'($urandom_range(0, 7));
      d  = int'($urandom_range(0, 255));
      if (a == 6 && $urandom_range(0, 3) == 0) d = 'h3F;
      do_op(rw, a, d);
      total++; if (got_rdata !== 8'(mrdata)) $display("FAIL rnd%0d rdata got %h exp %h", n, got_rdata, 8'(mrdata)); else passed++;
      total++; if (got_we !== 1'(exp_we)) $display("FAIL rnd%0d we got %b exp %b", n, got_we, 1'(exp_we)); else passed++;
      if (exp_we != 0) begin
        total++; if (got_waddr !== 16'(exp_waddr) || got_wdata !== 8'(exp_wdata))
          $display("FAIL rnd%0d waddr/wdata got %h/%h exp %h/%h", n, got_waddr, got_wdata, 16'(exp_waddr), 8'(exp_wdata)); else passed++;
      end
      total++; if (got_busy !== exp_busy) $display("FAIL rnd%0d busy got %0d exp %0d", n, got_busy, exp_busy); else passed++;
      total++; if (got_v !== 14'(mv)) $display("FAIL rnd%0d v got %h exp %h", n, got_v, 14'(mv)); else passed++;
    end
  endtask

  initial begin
    reset = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b0; cpu_addr = 3'd0; cpu_wdata = 8'h00;
    for (int i = 0; i < 16384; i++) begin
      ram[i]  = 8'($urandom);
      mram[i] = ram[i];
    end
    model_reset();
    test_reset();
    test_addr_write();
    test_back_to_back();
    test_buffered_read();
    test_toggle();
    test_palette();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
